vector_checker: RTL

VECTOR_CHECKER -- requirements
Module: vector_checker

---
 rtl/vector_checker.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vector_checker.sv
// vector_checker: steps {a,b,c} through all eight input vectors of a
// downstream combinational function, lets each settle for HOLD cycles,
// samples y once and compares it with the golden table EXPECTED. It
// reports the mismatch count and the index of the first failing vector.
module vector_checker #(
   parameter int unsigned HOLD     = 1,      // settle cycles per vector, 1..15
   parameter logic [7:0]  EXPECTED = 8'h31   // bit i = golden y for {a,b,c}=i
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail,
   output logic       first_fail_valid
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Last hold-counter value before leaving DRIVE.
   localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q,   idx_d;
   logic [3:0] hold_q,  hold_d;
   logic [3:0] err_q,   err_d;
   logic [2:0] ff_q,    ff_d;
   logic       ffv_q,   ffv_d;

   // Next-state and datapath update for the run sequencer.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case statement leaves one unassigned, which would infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      err_d   = err_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = DRIVE;
               idx_d   = 3'd0;
               hold_d  = 4'd0;
               err_d   = 4'd0;
               ff_d    = 3'd0;
               ffv_d   = 1'b0;
            end
         end

         DRIVE: begin
            if (hold_q == HOLD_LAST) begin
               state_d = SAMPLE;
               hold_d  = 4'd0;
            end else begin
               hold_d  = hold_q + 4'd1;
            end
         end

         SAMPLE: begin
            // Written as match/else so an unknown y lands in the mismatch branch.
            if (y == EXPECTED[idx_q]) begin
            end else begin
               err_d = err_q + 4'd1;
               if (!ffv_q) begin
                  ff_d  = idx_q;
                  ffv_d = 1'b1;
               end
            end

            if (idx_q == 3'd7) begin
               state_d = DONE;
               idx_d   = 3'd0;
            end else begin
               state_d = DRIVE;
               idx_d   = idx_q + 3'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any run in progress and its results.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         hold_q  <= 4'd0;
         err_q   <= 4'd0;
         ff_q    <= 3'd0;
         ffv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
      end
   end

   // Stimulus comes straight from the index register; idx is zero outside a run.
   assign {a, b, c}        = idx_q;
   assign busy             = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done             = (state_q == DONE);
   assign pass             = (state_q == DONE) && (err_q == 4'd0);
   assign err_count        = err_q;
   assign first_fail       = ff_q;
   assign first_fail_valid = ffv_q;

endmodule
